// File: rtl/alu_ops_pkg.sv
// Shared encodings for the SPAM-1 core: ALU opcodes, bus sources, targets,
// jump conditions and the instruction field layout.
package alu_ops;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 48;

    localparam int ALUOP_MSB  = 47;
    localparam int ALUOP_LSB  = 43;
    localparam int TARGET_MSB = 42;
    localparam int TARGET_LSB = 38;
    localparam int ASEL_MSB   = 37;
    localparam int ASEL_LSB   = 35;
    localparam int BSEL_MSB   = 34;
    localparam int BSEL_LSB   = 32;
    localparam int COND_MSB   = 31;
    localparam int COND_LSB   = 28;
    localparam int RSVD_MSB   = 27;
    localparam int RSVD_LSB   = 24;
    localparam int ADDR_MSB   = 23;
    localparam int ADDR_LSB   = 8;
    localparam int IMMED_MSB  = 7;
    localparam int IMMED_LSB  = 0;

    typedef enum logic [4:0] {
        ALU_ZERO            = 5'd0,
        ALU_A               = 5'd1,
        ALU_B               = 5'd2,
        ALU_A_PLUS_B        = 5'd3,
        ALU_A_MINUS_B       = 5'd4,
        ALU_A_PLUS_B_PLUS_C = 5'd5,
        ALU_B_PLUS_1        = 5'd6,
        ALU_A_AND_B         = 5'd7
    } alu_op_e;

    localparam logic [4:0] TGT_REGA  = 5'd0;
    localparam logic [4:0] TGT_REGB  = 5'd1;
    localparam logic [4:0] TGT_REGC  = 5'd2;
    localparam logic [4:0] TGT_REGD  = 5'd3;
    localparam logic [4:0] TGT_MARLO = 5'd4;
    localparam logic [4:0] TGT_MARHI = 5'd5;
    localparam logic [4:0] TGT_UART  = 5'd6;
    localparam logic [4:0] TGT_RAM   = 5'd7;
    localparam logic [4:0] TGT_JUMP  = 5'd8;

    localparam logic [2:0] SRC_REGA  = 3'd0;
    localparam logic [2:0] SRC_REGB  = 3'd1;
    localparam logic [2:0] SRC_REGC  = 3'd2;
    localparam logic [2:0] SRC_REGD  = 3'd3;
    localparam logic [2:0] SRC_MARLO = 3'd4;
    localparam logic [2:0] SRC_MARHI = 3'd5;
    localparam logic [2:0] SRC_UART  = 3'd6;
    localparam logic [2:0] SRC_ZERO  = 3'd7;
    localparam logic [2:0] SRC_IMMED = 3'd6;
    localparam logic [2:0] SRC_RAM   = 3'd7;

    localparam logic [3:0] COND_ALWAYS = 4'd0;
    localparam logic [3:0] COND_C      = 4'd1;
    localparam logic [3:0] COND_Z      = 4'd2;
    localparam logic [3:0] COND_DI     = 4'd3;
    localparam logic [3:0] COND_DO     = 4'd4;
    localparam logic [3:0] COND_NEVER  = 4'd5;
    localparam logic [3:0] COND_NOT_C  = 4'd6;
    localparam logic [3:0] COND_NOT_Z  = 4'd7;

    function automatic logic cond_met(input logic [3:0] cond, input logic c,
                                      input logic z, input logic di, input logic dout);
        case (cond)
            COND_ALWAYS: return 1'b1;
            COND_C:      return c;
            COND_Z:      return z;
            COND_DI:     return di;
            COND_DO:     return dout;
            COND_NOT_C:  return !c;
            COND_NOT_Z:  return !z;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// 8-bit ALU: result plus carry/borrow from a 9-bit internal sum and a zero flag.
module cpu_alu
    import alu_ops::*;
(
    input  alu_op_e     aluop,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        cin,
    output logic [7:0]  result,
    output logic        cout,
    output logic        zero
);

    logic [8:0] sum9;

    always_comb begin
        sum9 = 9'd0;
        case (aluop)
            ALU_A:               sum9 = {1'b0, a};
            ALU_B:               sum9 = {1'b0, b};
            ALU_A_PLUS_B:        sum9 = {1'b0, a} + {1'b0, b};
            ALU_A_MINUS_B:       sum9 = {1'b0, a} - {1'b0, b};
            ALU_A_PLUS_B_PLUS_C: sum9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            ALU_B_PLUS_1:        sum9 = {1'b0, b} + 9'd1;
            ALU_A_AND_B:         sum9 = {1'b0, a & b};
            default:             sum9 = 9'd0;
        endcase
    end

    // Bit 8 doubles as borrow for subtraction because the 9-bit difference wraps.
    assign result = sum9[7:0];
    assign cout   = sum9[8];
    assign zero   = (sum9[7:0] == 8'd0);

endmodule

// File: rtl/cpu.sv
// SPAM-1 core: two-phase fetch/exec of 48-bit ROM instructions, each routing
// one ALU result to a register, MAR, RAM, the UART, or the program counter.
module cpu
    import alu_ops::*;
#(
    parameter string ROM_FILE = ""
) (
    input  logic        RESET_SWITCH,
    input  logic        clk,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ack,
    input  logic        uart_tx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_write
);

    logic [INSTR_W-1:0] rom [0:65535];

    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               phase_exec_q, phase_exec_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [7:0]         rega_q, rega_d, regb_q, regb_d, regc_q, regc_d, regd_q, regd_d;
    logic [7:0]         marlo_q, marlo_d, marhi_q, marhi_d;
    logic               flag_c_q, flag_c_d, flag_z_q, flag_z_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_write_q, tx_write_d, rx_ack_q, rx_ack_d;

    logic [4:0]  target;
    logic [2:0]  asel, bsel;
    logic [3:0]  cond;
    logic [15:0] addr16;
    logic [7:0]  immed8;
    logic [7:0]  a_bus, b_bus, alu_result, ram_rd;
    logic        alu_cout, alu_zero, ram_we, unused_rsvd;
    logic [15:0] mar;

    assign target      = ir_q[TARGET_MSB:TARGET_LSB];
    assign asel        = ir_q[ASEL_MSB:ASEL_LSB];
    assign bsel        = ir_q[BSEL_MSB:BSEL_LSB];
    assign cond        = ir_q[COND_MSB:COND_LSB];
    assign addr16      = ir_q[ADDR_MSB:ADDR_LSB];
    assign immed8      = ir_q[IMMED_MSB:IMMED_LSB];
    assign unused_rsvd = ^ir_q[RSVD_MSB:RSVD_LSB];
    assign mar         = {marhi_q, marlo_q};

    always_comb begin
        case (asel)
            SRC_REGA:  a_bus = rega_q;
            SRC_REGB:  a_bus = regb_q;
            SRC_REGC:  a_bus = regc_q;
            SRC_REGD:  a_bus = regd_q;
            SRC_MARLO: a_bus = marlo_q;
            SRC_MARHI: a_bus = marhi_q;
            SRC_UART:  a_bus = uart_rx_data;
            default:   a_bus = 8'd0;
        endcase
        case (bsel)
            SRC_REGA:  b_bus = rega_q;
            SRC_REGB:  b_bus = regb_q;
            SRC_REGC:  b_bus = regc_q;
            SRC_REGD:  b_bus = regd_q;
            SRC_MARLO: b_bus = marlo_q;
            SRC_MARHI: b_bus = marhi_q;
            SRC_IMMED: b_bus = immed8;
            default:   b_bus = ram_rd;
        endcase
    end

    cpu_alu u_alu (
        .aluop  (alu_op_e'(ir_q[ALUOP_MSB:ALUOP_LSB])),
        .a      (a_bus),
        .b      (b_bus),
        .cin    (flag_c_q),
        .result (alu_result),
        .cout   (alu_cout),
        .zero   (alu_zero)
    );

    // RAM is kept in a named block so its storage is reachable as ram64.Mem.
    assign ram_we = phase_exec_q && (target == TGT_RAM);

    if (1) begin : ram64
        logic [7:0] Mem [0:65535];

        always_ff @(posedge clk) begin
            if (ram_we) Mem[mar] <= alu_result;
        end

        assign ram_rd = Mem[mar];
    end

    always_comb begin
        ir_d         = ir_q;
        phase_exec_d = phase_exec_q;
        pc_d         = pc_q;
        rega_d       = rega_q;
        regb_d       = regb_q;
        regc_d       = regc_q;
        regd_d       = regd_q;
        marlo_d      = marlo_q;
        marhi_d      = marhi_q;
        flag_c_d     = flag_c_q;
        flag_z_d     = flag_z_q;
        tx_data_d    = tx_data_q;
        tx_write_d   = 1'b0;
        rx_ack_d     = 1'b0;

        if (!phase_exec_q) begin
            ir_d         = rom[pc_q];
            phase_exec_d = 1'b1;
        end else begin
            phase_exec_d = 1'b0;
            pc_d         = pc_q + 16'd1;
            rx_ack_d     = (asel == SRC_UART);
            // Jumps leave the flags alone so a carry survives across them.
            if (target == TGT_JUMP) begin
                if (cond_met(cond, flag_c_q, flag_z_q, uart_rx_valid, uart_tx_ready))
                    pc_d = addr16;
            end else begin
                flag_c_d = alu_cout;
                flag_z_d = alu_zero;
                case (target)
                    TGT_REGA:  rega_d  = alu_result;
                    TGT_REGB:  regb_d  = alu_result;
                    TGT_REGC:  regc_d  = alu_result;
                    TGT_REGD:  regd_d  = alu_result;
                    TGT_MARLO: marlo_d = alu_result;
                    TGT_MARHI: marhi_d = alu_result;
                    TGT_UART: begin
                        tx_data_d  = alu_result;
                        tx_write_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge RESET_SWITCH) begin
        if (RESET_SWITCH) begin
            ir_q         <= '0;
            phase_exec_q <= 1'b0;
            pc_q         <= '0;
            rega_q       <= '0;
            regb_q       <= '0;
            regc_q       <= '0;
            regd_q       <= '0;
            marlo_q      <= '0;
            marhi_q      <= '0;
            flag_c_q     <= 1'b0;
            flag_z_q     <= 1'b0;
            tx_data_q    <= '0;
            tx_write_q   <= 1'b0;
            rx_ack_q     <= 1'b0;
        end else begin
            ir_q         <= ir_d;
            phase_exec_q <= phase_exec_d;
            pc_q         <= pc_d;
            rega_q       <= rega_d;
            regb_q       <= regb_d;
            regc_q       <= regc_d;
            regd_q       <= regd_d;
            marlo_q      <= marlo_d;
            marhi_q      <= marhi_d;
            flag_c_q     <= flag_c_d;
            flag_z_q     <= flag_z_d;
            tx_data_q    <= tx_data_d;
            tx_write_q   <= tx_write_d;
            rx_ack_q     <= rx_ack_d;
        end
    end

    assign uart_tx_data  = tx_data_q;
    assign uart_tx_write = tx_write_q;
    assign uart_rx_ack   = rx_ack_q;

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the SPAM-1 core: programs the ROM hierarchically and
// checks architectural state and UART strobes against hand-derived values.
module tb_cpu;

    localparam logic [4:0] OP_ZERO = 5'd0, OP_A = 5'd1, OP_B = 5'd2, OP_ADD = 5'd3;
    localparam logic [4:0] OP_ADC = 5'd5;
    localparam logic [4:0] T_A = 5'd0, T_B = 5'd1, T_C = 5'd2, T_D = 5'd3;
    localparam logic [4:0] T_MLO = 5'd4, T_MHI = 5'd5, T_UART = 5'd6, T_JMP = 5'd8;
    localparam logic [2:0] S_A = 3'd0, S_B = 3'd1, S_D = 3'd3, S_RX = 3'd6, S_ZERO = 3'd7;
    localparam logic [2:0] S_IMM = 3'd6;
    localparam logic [3:0] C_ALW = 4'd0, C_DI = 4'd3, C_DO = 4'd4;
    localparam logic [4:0] OP_INC = 5'd6;

    logic       RESET_SWITCH, clk;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid, uart_rx_ack, uart_tx_ready, uart_tx_write;
    logic [7:0] uart_tx_data;

    int n_checks = 0;
    int n_fail   = 0;

    cpu #(.ROM_FILE("")) dut (
        .RESET_SWITCH  (RESET_SWITCH),
        .clk           (clk),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ack   (uart_rx_ack),
        .uart_tx_ready (uart_tx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_write (uart_tx_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] mk(input logic [4:0] op, input logic [4:0] tgt,
                                       input logic [2:0] as, input logic [2:0] bs,
                                       input logic [3:0] cnd, input logic [15:0] ad,
                                       input logic [7:0] im);
        return {op, tgt, as, bs, cnd, 4'b0000, ad, im};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) dut.rom[i] = 48'h0;
    endtask

    task automatic do_reset();
        RESET_SWITCH = 1'b1;
        tick(1);
        RESET_SWITCH = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        dut.rom[0] = mk(OP_B,   T_D,    S_A, S_IMM, C_ALW, 16'h0, 8'hC3);
        dut.rom[1] = mk(OP_B,   T_UART, S_A, S_IMM, C_ALW, 16'h0, 8'h3C);
        dut.rom[2] = mk(OP_ADD, T_MHI,  S_D, S_IMM, C_ALW, 16'h0, 8'h80);
        do_reset();
        tick(6);
        n_checks++;
        if (dut.regd_q !== 8'hC3) begin n_fail++; $display("FAIL pre_reset_regd: got %h expected c3", dut.regd_q); end
        n_checks++;
        if ({dut.flag_c_q, dut.marhi_q} !== 9'h143) begin
            n_fail++; $display("FAIL pre_reset_marhi_c: got %h expected 143", {dut.flag_c_q, dut.marhi_q});
        end
        // assert reset between edges; it must act immediately
        #2;
        RESET_SWITCH = 1'b1;
        #1;
        n_checks++;
        if ({dut.pc_q, dut.phase_exec_q} !== 17'h0) begin
            n_fail++; $display("FAIL reset_pc_phase: got %h expected 0", {dut.pc_q, dut.phase_exec_q});
        end
        n_checks++;
        if (dut.ir_q !== 48'h0) begin n_fail++; $display("FAIL reset_ir: got %h expected 0", dut.ir_q); end
        n_checks++;
        if ({dut.rega_q, dut.regb_q, dut.regc_q, dut.regd_q, dut.marlo_q, dut.marhi_q} !== 48'h0) begin
            n_fail++; $display("FAIL reset_regs: got %h expected 0",
                               {dut.rega_q, dut.regb_q, dut.regc_q, dut.regd_q, dut.marlo_q, dut.marhi_q});
        end
        n_checks++;
        if ({dut.flag_c_q, dut.flag_z_q, uart_tx_data, uart_tx_write, uart_rx_ack} !== 12'h0) begin
            n_fail++; $display("FAIL reset_flags_uart: got %h expected 0",
                               {dut.flag_c_q, dut.flag_z_q, uart_tx_data, uart_tx_write, uart_rx_ack});
        end
        tick(1);
        RESET_SWITCH = 1'b0;
    endtask

    task automatic test_counter();
        logic [15:0] count;
        clear_rom();
        dut.rom[0] = mk(OP_A,   T_UART, S_A, S_A,   C_ALW, 16'h0, 8'h00);
        dut.rom[1] = mk(OP_ADD, T_A,    S_A, S_IMM, C_ALW, 16'h0, 8'h01);
        dut.rom[2] = mk(OP_ADC, T_B,    S_B, S_IMM, C_ALW, 16'h0, 8'h00);
        dut.rom[3] = mk(OP_INC, T_MLO,  S_A, S_A,   C_ALW, 16'h0, 8'h00);
        dut.rom[4] = mk(OP_ZERO, T_JMP, S_A, S_A,   C_ALW, 16'h0, 8'h00);
        uart_tx_ready = 1'b1;
        uart_rx_valid = 1'b0;
        do_reset();
        count = 16'h0;
        for (int k = 0; k < 4; k++) begin
            tick(2);
            n_checks++;
            if ({uart_tx_write, uart_tx_data} !== {1'b1, count[7:0]}) begin
                n_fail++; $display("FAIL counter_tx loop %0d: got %h expected %h", k,
                                   {uart_tx_write, uart_tx_data}, {1'b1, count[7:0]});
            end
            tick(1);
            n_checks++;
            if (uart_tx_write !== 1'b0) begin n_fail++; $display("FAIL counter_tx_pulse loop %0d: got %b expected 0", k, uart_tx_write); end
            tick(5);
            count = count + 16'd1;
            n_checks++;
            if ({dut.regb_q, dut.rega_q} !== count) begin
                n_fail++; $display("FAIL counter_value loop %0d: got %h expected %h", k, {dut.regb_q, dut.rega_q}, count);
            end
            n_checks++;
            if (dut.marlo_q !== count[7:0] + 8'd1) begin
                n_fail++; $display("FAIL counter_marlo loop %0d: got %h expected %h", k, dut.marlo_q, count[7:0] + 8'd1);
            end
            tick(2);
            n_checks++;
            if (dut.pc_q !== 16'h0) begin n_fail++; $display("FAIL counter_jump loop %0d: got %h expected 0000", k, dut.pc_q); end
        end
    endtask

    task automatic test_rollover();
        clear_rom();
        dut.rom[0] = mk(OP_B,    T_A, S_A, S_IMM, C_ALW, 16'h0, 8'hFF);
        dut.rom[1] = mk(OP_ZERO, T_B, S_A, S_A,   C_ALW, 16'h0, 8'h00);
        dut.rom[2] = mk(OP_ADD,  T_A, S_A, S_IMM, C_ALW, 16'h0, 8'h01);
        dut.rom[3] = mk(OP_ADC,  T_B, S_B, S_IMM, C_ALW, 16'h0, 8'h00);
        dut.rom[4] = mk(OP_B,    T_A, S_A, S_IMM, C_ALW, 16'h0, 8'hFF);
        dut.rom[5] = mk(OP_B,    T_B, S_A, S_IMM, C_ALW, 16'h0, 8'hFF);
        dut.rom[6] = mk(OP_ADD,  T_A, S_A, S_IMM, C_ALW, 16'h0, 8'h01);
        dut.rom[7] = mk(OP_ADC,  T_B, S_B, S_IMM, C_ALW, 16'h0, 8'h00);
        do_reset();
        tick(6);
        n_checks++;
        if ({dut.rega_q, dut.flag_c_q, dut.flag_z_q} !== 10'b0000_0000_11) begin
            n_fail++; $display("FAIL rollover_rega_cz: got %h/%b%b expected 00/11", dut.rega_q, dut.flag_c_q, dut.flag_z_q);
        end
        tick(2);
        n_checks++;
        if ({dut.regb_q, dut.flag_c_q} !== 9'h002) begin
            n_fail++; $display("FAIL rollover_regb: got %h/%b expected 01/0", dut.regb_q, dut.flag_c_q);
        end
        tick(8);
        n_checks++;
        if ({dut.regb_q, dut.rega_q, dut.flag_c_q, dut.flag_z_q} !== 18'h00003) begin
            n_fail++; $display("FAIL rollover_ffff: got %h%h/%b%b expected 0000/11",
                               dut.regb_q, dut.rega_q, dut.flag_c_q, dut.flag_z_q);
        end
    endtask

    task automatic test_uart_read();
        clear_rom();
        dut.rom[0] = mk(OP_A, T_MHI, S_RX, S_A, C_ALW, 16'h0, 8'h00);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h5A;
        do_reset();
        tick(1);
        n_checks++;
        if (uart_rx_ack !== 1'b0) begin n_fail++; $display("FAIL uart_ack_early: got %b expected 0", uart_rx_ack); end
        tick(1);
        n_checks++;
        if ({dut.marhi_q, uart_rx_ack} !== {8'h5A, 1'b1}) begin
            n_fail++; $display("FAIL uart_read: got %h/%b expected 5a/1", dut.marhi_q, uart_rx_ack);
        end
        tick(1);
        n_checks++;
        if (uart_rx_ack !== 1'b0) begin n_fail++; $display("FAIL uart_ack_pulse: got %b expected 0", uart_rx_ack); end
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;
    endtask

    task automatic test_di_do_loop();
        logic [15:0] exp_pc;
        clear_rom();
        dut.rom[0]     = mk(OP_B,    T_A,    S_A, S_IMM, C_ALW, 16'h0000, 8'h42);
        dut.rom[1]     = mk(OP_ZERO, T_JMP,  S_A, S_A,   C_ALW, 16'h0010, 8'h00);
        dut.rom[16]    = mk(OP_ZERO, T_JMP,  S_A, S_A,   C_DI,  16'h0020, 8'h00);
        dut.rom[17]    = mk(OP_ZERO, T_JMP,  S_A, S_A,   C_DO,  16'h0030, 8'h00);
        dut.rom[18]    = mk(OP_ZERO, T_JMP,  S_A, S_A,   C_ALW, 16'h0010, 8'h00);
        dut.rom[32]    = mk(OP_A,    T_UART, S_RX, S_A,  C_ALW, 16'h0000, 8'h00);
        dut.rom[48]    = mk(OP_B,    T_UART, S_A, S_IMM, C_ALW, 16'h0000, 8'hEE);
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b0;
        do_reset();
        tick(4);
        exp_pc = 16'h0010;
        n_checks++;
        if (dut.pc_q !== exp_pc) begin n_fail++; $display("FAIL loop_entry: got %h expected %h", dut.pc_q, exp_pc); end
        for (int i = 0; i < 6; i++) begin
            tick(2);
            exp_pc = (exp_pc == 16'h0012) ? 16'h0010 : exp_pc + 16'd1;
            n_checks++;
            if ({dut.pc_q, uart_tx_write, uart_rx_ack} !== {exp_pc, 2'b00}) begin
                n_fail++; $display("FAIL loop_pc step %0d: got %h/%b%b expected %h/00", i,
                                   dut.pc_q, uart_tx_write, uart_rx_ack, exp_pc);
            end
        end
        n_checks++;
        if ({dut.rega_q, dut.flag_c_q, dut.flag_z_q, uart_tx_data} !== {8'h42, 2'b00, 8'h00}) begin
            n_fail++; $display("FAIL loop_state: got %h/%b%b/%h expected 42/00/00",
                               dut.rega_q, dut.flag_c_q, dut.flag_z_q, uart_tx_data);
        end
        uart_tx_ready = 1'b1;
    endtask

    task automatic test_jump_flags();
        clear_rom();
        dut.rom[0] = mk(OP_B,    T_A,   S_A,    S_IMM, C_ALW, 16'h0000, 8'hFF);
        dut.rom[1] = mk(OP_ADD,  T_B,   S_A,    S_IMM, C_ALW, 16'h0000, 8'h01);
        dut.rom[2] = mk(OP_ZERO, T_JMP, S_A,    S_A,   C_ALW, 16'h0003, 8'h00);
        dut.rom[3] = mk(OP_ADC,  T_C,   S_ZERO, S_IMM, C_ALW, 16'h0000, 8'h00);
        do_reset();
        tick(6);
        n_checks++;
        if ({dut.pc_q, dut.flag_c_q} !== {16'h0003, 1'b1}) begin
            n_fail++; $display("FAIL jump_keeps_c: got %h/%b expected 0003/1", dut.pc_q, dut.flag_c_q);
        end
        tick(2);
        n_checks++;
        if ({dut.regc_q, dut.flag_c_q} !== {8'h01, 1'b0}) begin
            n_fail++; $display("FAIL jump_adc: got %h/%b expected 01/0", dut.regc_q, dut.flag_c_q);
        end
    endtask

    task automatic test_reset_mid_exec();
        clear_rom();
        dut.rom[0] = mk(OP_B, T_A, S_A, S_IMM, C_ALW, 16'h0000, 8'h77);
        do_reset();
        tick(1);
        n_checks++;
        if (dut.phase_exec_q !== 1'b1) begin n_fail++; $display("FAIL midexec_phase: got %b expected 1", dut.phase_exec_q); end
        RESET_SWITCH = 1'b1;
        #1;
        n_checks++;
        if ({dut.rega_q, dut.pc_q, dut.phase_exec_q} !== 25'h0) begin
            n_fail++; $display("FAIL midexec_reset: got %h/%h/%b expected 00/0000/0", dut.rega_q, dut.pc_q, dut.phase_exec_q);
        end
        tick(1);
        n_checks++;
        if (dut.rega_q !== 8'h00) begin n_fail++; $display("FAIL midexec_hold: got %h expected 00", dut.rega_q); end
        RESET_SWITCH = 1'b0;
        tick(1);
        n_checks++;
        if ({dut.ir_q, dut.phase_exec_q} !== {mk(OP_B, T_A, S_A, S_IMM, C_ALW, 16'h0000, 8'h77), 1'b1}) begin
            n_fail++; $display("FAIL restart_fetch: got %h/%b expected rom[0]/1", dut.ir_q, dut.phase_exec_q);
        end
        tick(1);
        n_checks++;
        if ({dut.rega_q, dut.pc_q} !== {8'h77, 16'h0001}) begin
            n_fail++; $display("FAIL restart_exec: got %h/%h expected 77/0001", dut.rega_q, dut.pc_q);
        end
    endtask

    initial begin
        RESET_SWITCH  = 1'b1;
        uart_rx_data  = 8'h00;
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b1;
        clear_rom();
        tick(2);
        test_reset();
        test_counter();
        test_rollover();
        test_uart_read();
        test_di_do_loop();
        test_jump_flags();
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
